// File: rtl/sat_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sat_accumulator                                               |
// | Purpose  : Per-neuron reduction stage. Sums exactly FANIN signed terms   |
// |            plus a bias using width-bit two's-complement saturating       |
// |            addition, then holds one registered result for downstream.   |
// | Ports    : clk        - clock, all state changes on the rising edge      |
// |            reset_n    - synchronous active-low reset                     |
// |            bias       - bias, sampled with the first term of a group     |
// |            in_data    - signed product term                              |
// |            in_valid   - in_data is valid                                 |
// |            in_ready   - block accepts a term (ACCUM state)               |
// |            out_data   - accumulated result (registered)                  |
// |            out_valid  - out_data holds a completed result (HOLD state)   |
// |            out_ready  - downstream accepts the result                    |
// |            ovf        - saturation occurred in this result               |
// |                         (only with SAT_ACC_OVF_FLAG_EN defined)          |
// | Options  : SAT_ACC_OVF_FLAG_EN - adds the registered ovf flag            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sat_accumulator #(
   parameter int WIDTH = 8,
   parameter int FANIN = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] bias,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
`ifdef SAT_ACC_OVF_FLAG_EN
   ,
   output logic             ovf
`endif
);

   // Term counter is at least one bit wide so FANIN=1 still builds.
   localparam int CNT_W = (FANIN > 1) ? $clog2(FANIN) : 1;

   localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(FANIN - 1);
   localparam logic [WIDTH-1:0] c_POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_NEG_MAX  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [0:0] {
      S_ACCUM = 1'b0,
      S_HOLD  = 1'b1
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   acc_d;

   logic               w_first;
   logic               w_last;
   logic [WIDTH-1:0]   w_op_a;
   logic [WIDTH-1:0]   w_raw;
   logic               w_sat;

   // The first term of a group adds to the bias instead of the previous
   // result, which is how the held value gets discarded.
   assign w_first = (cnt_q == '0);
   assign w_last  = (cnt_q == c_LAST_CNT);
   assign w_op_a  = w_first ? bias : acc_q;
   assign w_raw   = w_op_a + in_data;

   // Overflow only when both operands share a sign and the sum flips it.
   assign w_sat   = (w_op_a[WIDTH-1] == in_data[WIDTH-1]) &&
                    (w_raw[WIDTH-1]  != w_op_a[WIDTH-1]);
   assign acc_d   = w_sat ? (w_op_a[WIDTH-1] ? c_NEG_MAX : c_POS_MAX) : w_raw;

   // Handshake outputs depend on the state register only.
   assign in_ready  = (state_q == S_ACCUM);
   assign out_valid = (state_q == S_HOLD);
   assign out_data  = acc_q;

`ifdef SAT_ACC_OVF_FLAG_EN
   logic ovf_q;
   logic ovf_d;

   // The flag restarts with each group and sticks until the next group.
   assign ovf_d = w_first ? w_sat : (ovf_q | w_sat);
   assign ovf   = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_ACCUM;
         cnt_q   <= '0;
         acc_q   <= '0;
`ifdef SAT_ACC_OVF_FLAG_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_ACCUM: begin
               if (in_valid) begin
                  acc_q <= acc_d;
`ifdef SAT_ACC_OVF_FLAG_EN
                  ovf_q <= ovf_d;
`endif
                  if (w_last) begin
                     cnt_q   <= '0;
                     state_q <= S_HOLD;
                  end else begin
                     cnt_q   <= cnt_q + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  state_q <= S_ACCUM;
               end
            end
            default: begin
               state_q <= S_ACCUM;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
